relu_layer_sequencer: RTL
=========================

// Module: relu_layer_sequencer
// PURPOSE
//  Streams one layer's accumulator results through the reLU unit, element by element, into the activation buffer.
//  Sits between the accumulator SRAM (read port), the reLU unit (DATA_IN/EN_reLU/BYPASS_reLU -> reLU_OUT,
//  1-cycle registered) and the activation SRAM (write port). The top-level layer controller starts it.
//  Asserts BYPASS_reLU for the output (logit) layer so signed values pass unclipped.
// PARAMETERS
//  DATA_W   16  element width (two's complement)
//  ADDR_W   10  buffer address width; also width of LAYER_LEN
// PORTS
//  CLKEXT       in   1       system clock, rising edge
//  RST          in   1       asynchronous, active-low reset
//  START        in   1       1-cycle pulse: begin a layer (accepted only in IDLE)
//  LAYER_LEN    in   ADDR_W  elements to process; sampled with START
//  SRC_BASE     in   ADDR_W  first accumulator address; sampled with START
//  DST_BASE     in   ADDR_W  first activation address; sampled with START
//  LAST_LAYER   in   1       1 = bypass ReLU for this run; sampled with START
//  HOLD         in   1       1 = issue no new reads this cycle (in-flight elements still complete)
//  SRC_RD_EN    out  1       accumulator read strobe
//  SRC_ADDR     out  ADDR_W  accumulator read address
//  SRC_DATA     in   DATA_W  read data, valid exactly 1 cycle after SRC_RD_EN
//  DATA_IN      out  DATA_W  to reLU unit
//  EN_reLU      out  1       to reLU unit
//  BYPASS_reLU  out  1       to reLU unit
//  reLU_OUT     in   DATA_W  from reLU unit, valid 1 cycle after EN_reLU
//  DST_WR_EN    out  1       activation write strobe
//  DST_ADDR     out  ADDR_W  activation write address
//  DST_DATA     out  DATA_W  activation write data (= reLU_OUT)
//  BUSY         out  1       high from accepted START until DONE
//  DONE         out  1       1-cycle pulse: last element written
//  ERR          out  1       1-cycle pulse: START rejected while BUSY
// BEHAVIOUR
//  Reset (RST=0, any time incl. mid-layer): state IDLE; all outputs 0; counters, valid flags, latched cfg cleared.
//    Any in-flight element is discarded (no write). A new START is required afterwards.
//  FSM: IDLE -> ISSUE (START, LAYER_LEN!=0) -> DRAIN (all reads issued) -> DONE (last write) -> IDLE.
//    IDLE + START + LAYER_LEN==0: go to DONE directly; DONE pulses next cycle; no SRAM or reLU activity.
//  Pipeline per element i (0..LAYER_LEN-1), no bubbles unless HOLD:
//    cycle t   : SRC_RD_EN=1, SRC_ADDR=(SRC_BASE+i) mod 2^ADDR_W (only in ISSUE with HOLD=0)
//    cycle t+1 : EN_reLU=1, DATA_IN=SRC_DATA (combinational pass-through); valid flag v1 set
//    cycle t+2 : DST_WR_EN=1, DST_ADDR=(DST_BASE+i) mod 2^ADDR_W, DST_DATA=reLU_OUT; valid flag v2 set
//    => 2-cycle read-to-write latency; throughput 1 element/cycle.
//    LAYER_LEN=N, HOLD=0: START at cycle 0 -> reads at 1..N, writes at 3..N+2, DONE at N+3, BUSY 1..N+3.
//  EN_reLU=0 and DATA_IN=0 whenever v1=0 (no stray reLU updates).
//  BYPASS_reLU = latched LAST_LAYER for the whole run (held from START through DONE); 0 in IDLE.
//  HOLD: gates read issue only; reads already issued flow through and are written. Release resumes at next index.
//    HOLD is ignored in IDLE/DRAIN/DONE.
//  Address counters wrap modulo 2^ADDR_W independently (e.g. SRC_BASE=0x3FE, LEN=4 -> 3FE,3FF,000,001).
//  START while BUSY: ignored (cfg not resampled), ERR pulses for 1 cycle.
//  START in the same cycle DONE is high: rejected (ERR) — DONE state is still BUSY.
//  ISSUE->DRAIN when the issue counter reaches LAYER_LEN; DRAIN->DONE on the write of element LAYER_LEN-1.
//  DONE and ERR are registered 1-cycle pulses.
// TESTING
//  1 Basic: LEN=4, SRC_BASE=0x010, DST_BASE=0x100, LAST_LAYER=0, src={1234,-1,0,-32768}
//    -> writes 0x100..0x103 = {1234,0,0,0}; DONE at START+7; BUSY high 7 cycles.
//  2 Bypass: same data, LAST_LAYER=1 -> dst={1234,0xFFFF,0,0x8000}; BYPASS_reLU high START+1..DONE.
//  3 HOLD: LEN=8, HOLD high for 3 cycles after 2nd read -> exactly 8 writes, in order, no duplicates;
//    DONE delayed by 3 cycles vs no-HOLD.
//  4 Wrap/zero: SRC_BASE=0x3FE, DST_BASE=0x3FF, LEN=3 -> reads 3FE,3FF,000; writes 3FF,000,001.
//    LEN=0 -> DONE pulses with no RD/WR/EN_reLU activity.
//  5 START while busy (LEN=16, 2nd START at cycle 5) -> ERR 1 pulse; run completes with original cfg.
//  6 Reset mid-run: RST low at 3rd write -> all outputs 0 immediately; no further writes after release;
//    new START LEN=2 works normally.

Source files
------------

// File: rtl/relu_layer_sequencer.sv
// Streams one layer of accumulator results through the reLU unit into the activation buffer.
// Read -> reLU -> write pipeline, one element per cycle, with an optional ReLU bypass for the logit layer.
module relu_layer_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              CLKEXT,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] LAYER_LEN,
  input  logic [ADDR_W-1:0] SRC_BASE,
  input  logic [ADDR_W-1:0] DST_BASE,
  input  logic              LAST_LAYER,
  input  logic              HOLD,
  output logic              SRC_RD_EN,
  output logic [ADDR_W-1:0] SRC_ADDR,
  input  logic [DATA_W-1:0] SRC_DATA,
  output logic [DATA_W-1:0] DATA_IN,
  output logic              EN_reLU,
  output logic              BYPASS_reLU,
  input  logic [DATA_W-1:0] reLU_OUT,
  output logic              DST_WR_EN,
  output logic [ADDR_W-1:0] DST_ADDR,
  output logic [DATA_W-1:0] DST_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [1:0]        dbg_state_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic [ADDR_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              bypass_q, bypass_d;
  logic              v1_q, v1_d;
  logic              v2_q, v2_d;
  logic              err_q, err_d;
  logic              rd_en;

  // v1 marks an element whose read data is on SRC_DATA, v2 one whose reLU result is on reLU_OUT.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    src_addr_d  = src_addr_q;
    dst_addr_d  = dst_addr_q;
    issue_cnt_d = issue_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    bypass_d    = bypass_q;
    rd_en       = (state_q == S_ISSUE) && !HOLD;
    v1_d        = rd_en;
    v2_d        = v1_q;
    err_d       = START && (state_q != S_IDLE);

    if (rd_en) begin
      src_addr_d  = src_addr_q + ADDR_W'(1);
      issue_cnt_d = issue_cnt_q + ADDR_W'(1);
    end
    if (v2_q) begin
      dst_addr_d = dst_addr_q + ADDR_W'(1);
      wr_cnt_d   = wr_cnt_q + ADDR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (START) begin
          len_d       = LAYER_LEN;
          src_addr_d  = SRC_BASE;
          dst_addr_d  = DST_BASE;
          bypass_d    = LAST_LAYER;
          issue_cnt_d = '0;
          wr_cnt_d    = '0;
          state_d     = (LAYER_LEN == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (rd_en && (issue_cnt_q == len_q - ADDR_W'(1))) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (v2_q && (wr_cnt_q == len_q - ADDR_W'(1))) state_d = S_DONE;
      end
      S_DONE: begin
        state_d  = S_IDLE;
        bypass_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLKEXT or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      src_addr_q  <= '0;
      dst_addr_q  <= '0;
      issue_cnt_q <= '0;
      wr_cnt_q    <= '0;
      bypass_q    <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      src_addr_q  <= src_addr_d;
      dst_addr_q  <= dst_addr_d;
      issue_cnt_q <= issue_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      bypass_q    <= bypass_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      err_q       <= err_d;
    end
  end

  // Data/address outputs are gated by their strobes so idle buses stay at zero.
  assign SRC_RD_EN   = rd_en;
  assign SRC_ADDR    = rd_en ? src_addr_q : '0;
  assign EN_reLU     = v1_q;
  assign DATA_IN     = v1_q ? SRC_DATA : '0;
  assign BYPASS_reLU = bypass_q;
  assign DST_WR_EN   = v2_q;
  assign DST_ADDR    = v2_q ? dst_addr_q : '0;
  assign DST_DATA    = v2_q ? reLU_OUT : '0;
  assign BUSY        = (state_q != S_IDLE);
  assign DONE        = (state_q == S_DONE);
  assign ERR         = err_q;
  assign dbg_state_o = state_q;

endmodule
